// File: rtl/axi4_reg_slave_if.sv
// Bus bundle for axi4_reg_slave: AW/W/B write channels and AR/R read channels.
// The slave modport is the register block side; the master modport is the requester.
interface axi4_reg_slave_if #(
  parameter int IDLEN = 5
) ();
  logic             aw_valid;
  logic             aw_ready;
  logic [31:0]      aw_addr;
  logic [IDLEN-1:0] aw_id;
  logic             w_valid;
  logic             w_ready;
  logic [31:0]      w_data;
  logic [3:0]       w_strb;
  logic             b_valid;
  logic             b_ready;
  logic [1:0]       b_resp;
  logic [IDLEN-1:0] b_id;
  logic             ar_valid;
  logic             ar_ready;
  logic [31:0]      ar_addr;
  logic [IDLEN-1:0] ar_id;
  logic             r_valid;
  logic             r_ready;
  logic [31:0]      r_data;
  logic [1:0]       r_resp;
  logic [IDLEN-1:0] r_id;

  modport slave (
    input  aw_valid, aw_addr, aw_id, w_valid, w_data, w_strb, b_ready,
    input  ar_valid, ar_addr, ar_id, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, b_id,
    output ar_ready, r_valid, r_data, r_resp, r_id
  );

  modport master (
    output aw_valid, aw_addr, aw_id, w_valid, w_data, w_strb, b_ready,
    output ar_valid, ar_addr, ar_id, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, b_id,
    input  ar_ready, r_valid, r_data, r_resp, r_id
  );
endinterface

// File: rtl/axi4_reg_slave.sv
// AXI4 single-beat register slave: NREGS 32-bit registers at BASE_ADDR, register 0 a
// read-only ID constant. Independent write (AW/W/B) and read (AR/R) state machines.
module axi4_reg_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0002_0000,
  parameter int          NREGS     = 8,
  parameter int          IDLEN     = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi4_reg_slave_if.slave      bus,
  output logic [32*NREGS-1:0]  regs
);
  localparam logic [31:0] REG0_VALUE  = 32'hA5A5_0001;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_RESP} rstate_e;

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;

  logic aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic aw_hs, w_hs, ar_hs, commit;

  logic [31:0]      awaddr_q, awaddr_d;
  logic [IDLEN-1:0] awid_q, awid_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [1:0]       b_resp_q, b_resp_d;
  logic [IDLEN-1:0] b_id_q, b_id_d;
  logic [31:0]      r_data_q, r_data_d;
  logic [1:0]       r_resp_q, r_resp_d;
  logic [IDLEN-1:0] r_id_q, r_id_d;

  logic [31:0]      wr_addr, wr_data, rd_val;
  logic [3:0]       wr_strb;
  logic [IDLEN-1:0] wr_id;
  logic [29:0]      wr_idx, rd_idx;
  logic             wr_hit, rd_hit;
  logic [31:0]      reg_val [NREGS];

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
    end
  end

  // Next-state logic
  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE: begin
        if (bus.aw_valid && bus.w_valid) wstate_d = W_RESP;
        else if (bus.aw_valid)           wstate_d = W_HAVE_A;
        else if (bus.w_valid)            wstate_d = W_HAVE_D;
      end
      W_HAVE_A: if (bus.w_valid)  wstate_d = W_RESP;
      W_HAVE_D: if (bus.aw_valid) wstate_d = W_RESP;
      W_RESP:   if (bus.b_ready)  wstate_d = W_IDLE;
      default:  wstate_d = W_IDLE;
    endcase

    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (bus.ar_valid) rstate_d = R_RESP;
      R_RESP:  if (bus.r_ready)  rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  // State-decoded outputs; readies never look at the incoming valids
  always_comb begin
    aw_ready = (wstate_q == W_IDLE) || (wstate_q == W_HAVE_D);
    w_ready  = (wstate_q == W_IDLE) || (wstate_q == W_HAVE_A);
    b_valid  = (wstate_q == W_RESP);
    ar_ready = (rstate_q == R_IDLE);
    r_valid  = (rstate_q == R_RESP);
  end

  // Write datapath: merge the half captured earlier with the half arriving now
  always_comb begin
    aw_hs   = bus.aw_valid && aw_ready;
    w_hs    = bus.w_valid && w_ready;
    commit  = (wstate_q != W_RESP) && (wstate_d == W_RESP);
    wr_addr = (wstate_q == W_HAVE_A) ? awaddr_q : bus.aw_addr;
    wr_id   = (wstate_q == W_HAVE_A) ? awid_q   : bus.aw_id;
    wr_data = (wstate_q == W_HAVE_D) ? wdata_q  : bus.w_data;
    wr_strb = (wstate_q == W_HAVE_D) ? wstrb_q  : bus.w_strb;
    wr_idx  = 30'((wr_addr - BASE_ADDR) >> 2);
    wr_hit  = (wr_addr >= BASE_ADDR) && (wr_idx < 30'(NREGS));

    awaddr_d = aw_hs ? bus.aw_addr : awaddr_q;
    awid_d   = aw_hs ? bus.aw_id   : awid_q;
    wdata_d  = w_hs  ? bus.w_data  : wdata_q;
    wstrb_d  = w_hs  ? bus.w_strb  : wstrb_q;

    b_resp_d = b_resp_q;
    b_id_d   = b_id_q;
    if (commit) begin
      b_id_d = wr_id;
      if (!wr_hit)          b_resp_d = RESP_DECERR;
      else if (wr_idx == 0) b_resp_d = RESP_SLVERR;
      else                  b_resp_d = RESP_OKAY;
    end
  end

  // Read datapath: sampled from the register outputs, so a same-edge write is not seen
  always_comb begin
    ar_hs  = bus.ar_valid && ar_ready;
    rd_idx = 30'((bus.ar_addr - BASE_ADDR) >> 2);
    rd_hit = (bus.ar_addr >= BASE_ADDR) && (rd_idx < 30'(NREGS));
    rd_val = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_hit && rd_idx == 30'(i)) rd_val = reg_val[i];
    end

    r_data_d = r_data_q;
    r_resp_d = r_resp_q;
    r_id_d   = r_id_q;
    if (ar_hs) begin
      r_data_d = rd_val;
      r_resp_d = rd_hit ? RESP_OKAY : RESP_DECERR;
      r_id_d   = bus.ar_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awaddr_q <= '0;
      awid_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      b_resp_q <= '0;
      b_id_q   <= '0;
      r_data_q <= '0;
      r_resp_q <= '0;
      r_id_q   <= '0;
    end else begin
      awaddr_q <= awaddr_d;
      awid_q   <= awid_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      b_resp_q <= b_resp_d;
      b_id_q   <= b_id_d;
      r_data_q <= r_data_d;
      r_resp_q <= r_resp_d;
      r_id_q   <= r_id_d;
    end
  end

  // Register file: slot 0 is a constant, the rest update on the commit edge
  assign reg_val[0] = REG0_VALUE;

  for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
    logic [31:0] val_q, val_d;

    always_comb begin
      val_d = val_q;
      if (commit && wr_hit && wr_idx == 30'(gi)) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_strb[b]) val_d[8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) val_q <= '0;
      else        val_q <= val_d;
    end

    assign reg_val[gi] = val_q;
  end

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_out
    assign regs[32*gi +: 32] = reg_val[gi];
  end

  assign bus.aw_ready = aw_ready;
  assign bus.w_ready  = w_ready;
  assign bus.b_valid  = b_valid;
  assign bus.b_resp   = b_resp_q;
  assign bus.b_id     = b_id_q;
  assign bus.ar_ready = ar_ready;
  assign bus.r_valid  = r_valid;
  assign bus.r_data   = r_data_q;
  assign bus.r_resp   = r_resp_q;
  assign bus.r_id     = r_id_q;
endmodule

// File: tb/tb_axi4_reg_slave.sv
// Bench for axi4_reg_slave: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the register map and response queues.
module tb_axi4_reg_slave;
  localparam logic [31:0] BASE = 32'h0002_0000;
  localparam int          NR   = 8;
  localparam int          IDW  = 5;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [32*NR-1:0] regs;
  int tests = 0;
  int fails = 0;
  bit rand_done = 1'b0;

  axi4_reg_slave_if #(.IDLEN(IDW)) bus ();

  axi4_reg_slave #(.BASE_ADDR(BASE), .NREGS(NR), .IDLEN(IDW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .regs (regs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out, no handshake seen", name);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {logic [31:0] addr; logic [IDW-1:0] id;} a_t;
  typedef struct packed {logic [31:0] data; logic [3:0] strb;} w_t;
  typedef struct packed {logic [31:0] data; logic [1:0] resp; logic [IDW-1:0] id;} rsp_t;

  logic [31:0] mreg [NR];
  a_t   awq[$];
  w_t   wq[$];
  rsp_t bq[$];
  rsp_t rq[$];

  function automatic bit in_range(input logic [31:0] addr, output int idx);
    logic [31:0] word;
    idx = 0;
    if (addr < BASE) return 1'b0;
    word = (addr - BASE) / 4;
    if (word >= 32'(NR)) return 1'b0;
    idx = int'(word);
    return 1'b1;
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    int idx;
    logic [31:0] mask;
    if (!in_range(addr, idx)) return 2'b11;
    if (idx == 0) return 2'b10;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    mreg[idx] = (mreg[idx] & ~mask) | (data & mask);
    return 2'b00;
  endfunction

  function automatic void model_read(input logic [31:0] addr, output logic [31:0] data,
                                     output logic [1:0] resp);
    int idx;
    if (!in_range(addr, idx)) begin
      data = 32'h0;
      resp = 2'b11;
    end else begin
      data = mreg[idx];
      resp = 2'b00;
    end
  endfunction

  // ---------------- per-cycle compare process ----------------
  bit          exp_aw, exp_w, exp_ar;
  logic [31:0] md;
  logic [1:0]  mr;
  a_t          ta;
  w_t          tw;
  rsp_t        tr;

  always @(negedge clk) begin
    if (!rst_n) begin
      awq.delete();
      wq.delete();
      bq.delete();
      rq.delete();
      mreg[0] = 32'hA5A5_0001;
      for (int i = 1; i < NR; i++) mreg[i] = 32'h0;
    end else begin
      exp_aw = (awq.size() == 0) && (bq.size() == 0);
      exp_w  = (wq.size() == 0) && (bq.size() == 0);
      exp_ar = (rq.size() == 0);
      chk1("aw_ready", bus.aw_ready, exp_aw);
      chk1("w_ready", bus.w_ready, exp_w);
      chk1("ar_ready", bus.ar_ready, exp_ar);
      chk1("b_valid", bus.b_valid, bq.size() != 0);
      chk1("r_valid", bus.r_valid, rq.size() != 0);
      if (bq.size() != 0) begin
        chk("b_resp", 32'(bus.b_resp), 32'(bq[0].resp));
        chk("b_id", 32'(bus.b_id), 32'(bq[0].id));
      end
      if (rq.size() != 0) begin
        chk("r_data", bus.r_data, rq[0].data);
        chk("r_resp", 32'(bus.r_resp), 32'(rq[0].resp));
        chk("r_id", 32'(bus.r_id), 32'(rq[0].id));
      end
      for (int i = 0; i < NR; i++) chk($sformatf("regs[%0d]", i), regs[32*i +: 32], mreg[i]);

      // Handshakes that will complete on the coming rising edge; reads see pre-write state
      if (bq.size() != 0 && bus.b_ready) begin
        tr = bq.pop_front();
        $display("[TB] B  id=%0d resp=%0d", tr.id, tr.resp);
      end
      if (rq.size() != 0 && bus.r_ready) begin
        tr = rq.pop_front();
        $display("[TB] R  id=%0d resp=%0d data=%h", tr.id, tr.resp, tr.data);
      end
      if (exp_ar && bus.ar_valid) begin
        model_read(bus.ar_addr, md, mr);
        rq.push_back('{md, mr, bus.ar_id});
      end
      if (exp_aw && bus.aw_valid) awq.push_back('{bus.aw_addr, bus.aw_id});
      if (exp_w && bus.w_valid) wq.push_back('{bus.w_data, bus.w_strb});
      if (awq.size() != 0 && wq.size() != 0) begin
        ta = awq.pop_front();
        tw = wq.pop_front();
        mr = model_write(ta.addr, tw.data, tw.strb);
        bq.push_back('{32'h0, mr, ta.id});
      end
    end
  end

  // ---------------- channel drivers (all changes at posedge + 1) ----------------
  task automatic send_aw(input logic [31:0] addr, input logic [IDW-1:0] id, input int dly);
    repeat (dly + 1) @(posedge clk);
    #1;
    bus.aw_valid = 1'b1;
    bus.aw_addr  = addr;
    bus.aw_id    = id;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (bus.aw_ready) break;
      if (n == 200) begin timeout("aw_hs"); break; end
    end
    @(posedge clk);
    #1 bus.aw_valid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
    repeat (dly + 1) @(posedge clk);
    #1;
    bus.w_valid = 1'b1;
    bus.w_data  = data;
    bus.w_strb  = strb;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (bus.w_ready) break;
      if (n == 200) begin timeout("w_hs"); break; end
    end
    @(posedge clk);
    #1 bus.w_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [IDW-1:0] id, input int dly);
    repeat (dly + 1) @(posedge clk);
    #1;
    bus.ar_valid = 1'b1;
    bus.ar_addr  = addr;
    bus.ar_id    = id;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (bus.ar_ready) break;
      if (n == 200) begin timeout("ar_hs"); break; end
    end
    @(posedge clk);
    #1 bus.ar_valid = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input logic [IDW-1:0] id, input int awd, input int wd,
                    output logic [1:0] resp, output logic [IDW-1:0] rid);
    resp = 2'bxx;
    rid  = 'x;
    fork
      send_aw(addr, id, awd);
      send_w(data, strb, wd);
    join
    for (int n = 0; ; n++) begin
      if (bus.b_valid && bus.b_ready) begin
        resp = bus.b_resp;
        rid  = bus.b_id;
        break;
      end
      if (n == 200) begin timeout("b_hs"); break; end
      @(negedge clk);
    end
  endtask

  task automatic rd(input logic [31:0] addr, input logic [IDW-1:0] id,
                    output logic [31:0] data, output logic [1:0] resp);
    data = 'x;
    resp = 2'bxx;
    send_ar(addr, id, 0);
    for (int n = 0; ; n++) begin
      if (bus.r_valid && bus.r_ready) begin
        data = bus.r_data;
        resp = bus.r_resp;
        break;
      end
      if (n == 200) begin timeout("r_hs"); break; end
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k == 0)      a = BASE - 32'(4 * $urandom_range(1, 3));
    else if (k == 1) a = BASE + 32'(4 * (NR + $urandom_range(0, 3)));
    else             a = BASE + 32'(4 * $urandom_range(0, NR - 1));
    return a | 32'($urandom_range(0, 3));
  endfunction

  // ---------------- main sequence ----------------
  logic [1:0]     resp_r, resp_w;
  logic [IDW-1:0] id_r;
  logic [31:0]    data_r;

  initial begin
    bus.aw_valid = 1'b0; bus.aw_addr = '0; bus.aw_id = '0;
    bus.w_valid  = 1'b0; bus.w_data  = '0; bus.w_strb = '0;
    bus.ar_valid = 1'b0; bus.ar_addr = '0; bus.ar_id = '0;
    bus.b_ready  = 1'b1; bus.r_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk1("rst aw_ready", bus.aw_ready, 1'b1);
    chk1("rst w_ready", bus.w_ready, 1'b1);
    chk1("rst ar_ready", bus.ar_ready, 1'b1);
    chk1("rst b_valid", bus.b_valid, 1'b0);
    chk1("rst r_valid", bus.r_valid, 1'b0);
    chk("rst r_data", bus.r_data, 32'h0);
    chk("rst reg0", regs[31:0], 32'hA5A5_0001);
    chk("rst reg1", regs[63:32], 32'h0);

    wr(32'h0002_0004, 32'h1234_5678, 4'hF, 5'h13, 0, 0, resp_w, id_r);
    chk("aw+w resp", 32'(resp_w), 32'h0);
    chk("aw+w b_id", 32'(id_r), 32'h13);
    chk("aw+w reg1", regs[63:32], 32'h1234_5678);

    wr(32'h0002_0008, 32'hFFFF_FFFF, 4'b0101, 5'h07, 3, 0, resp_w, id_r);
    chk("w-first resp", 32'(resp_w), 32'h0);
    chk("w-first reg2", regs[95:64], 32'h00FF_00FF);

    rd(32'h0002_0000, 5'h01, data_r, resp_r);
    chk("reg0 read data", data_r, 32'hA5A5_0001);
    chk("reg0 read resp", 32'(resp_r), 32'h0);
    wr(32'h0002_0000, 32'hDEAD_BEEF, 4'hF, 5'h02, 0, 0, resp_w, id_r);
    chk("reg0 write resp", 32'(resp_w), 32'h2);
    chk("reg0 unchanged", regs[31:0], 32'hA5A5_0001);

    rd(32'h0002_0020, 5'h03, data_r, resp_r);
    chk("above read resp", 32'(resp_r), 32'h3);
    chk("above read data", data_r, 32'h0);
    rd(32'h0001_FFFC, 5'h04, data_r, resp_r);
    chk("below read resp", 32'(resp_r), 32'h3);
    chk("below read data", data_r, 32'h0);
    wr(32'h0002_0020, 32'h1111_1111, 4'hF, 5'h05, 0, 0, resp_w, id_r);
    chk("above write resp", 32'(resp_w), 32'h3);
    wr(32'h0001_FFFC, 32'h2222_2222, 4'hF, 5'h06, 0, 0, resp_w, id_r);
    chk("below write resp", 32'(resp_w), 32'h3);
    chk("decerr reg7 intact", regs[255:224], 32'h0);
    chk("decerr reg1 intact", regs[63:32], 32'h1234_5678);

    wr(32'h0002_0010, 32'h5555_5555, 4'h0, 5'h08, 0, 0, resp_w, id_r);
    chk("strb0 resp", 32'(resp_w), 32'h0);
    chk("strb0 reg4", regs[159:128], 32'h0);

    fork
      wr(32'h0002_000C, 32'hCAFE_F00D, 4'hF, 5'h09, 0, 0, resp_w, id_r);
      rd(32'h0002_000C, 5'h0A, data_r, resp_r);
    join
    chk("same-edge read old", data_r, 32'h0);
    rd(32'h0002_000C, 5'h0B, data_r, resp_r);
    chk("later read new", data_r, 32'hCAFE_F00D);

    @(posedge clk);
    #1 bus.b_ready = 1'b0;
    bus.r_ready = 1'b0;
    fork
      wr(32'h0002_0014, 32'hA1B2_C3D4, 4'hF, 5'h0C, 0, 0, resp_w, id_r);
      rd(32'h0002_0004, 5'h0D, data_r, resp_r);
      begin
        repeat (7) @(posedge clk);
        #1 bus.b_ready = 1'b1;
        bus.r_ready = 1'b1;
      end
    join
    chk("stall write resp", 32'(resp_w), 32'h0);
    chk("stall read data", data_r, 32'h1234_5678);

    fork
      begin
        fork
          for (int i = 0; i < 40; i++) send_aw(rand_addr(), IDW'($urandom), $urandom_range(0, 3));
          for (int i = 0; i < 40; i++) send_w($urandom, 4'($urandom), $urandom_range(0, 3));
          for (int i = 0; i < 40; i++) send_ar(rand_addr(), IDW'($urandom), $urandom_range(0, 3));
        join
        rand_done = 1'b1;
      end
      while (!rand_done) begin
        @(posedge clk);
        #1 bus.b_ready = ($urandom_range(0, 3) != 0);
        bus.r_ready = ($urandom_range(0, 3) != 0);
      end
    join
    @(posedge clk);
    #1 bus.b_ready = 1'b1;
    bus.r_ready = 1'b1;
    repeat (5) @(posedge clk);

    // Reset while a write response is pending
    #1 bus.b_ready = 1'b0;
    fork
      send_aw(32'h0002_0018, 5'h0E, 0);
      send_w(32'h7777_7777, 4'hF, 0);
    join
    @(negedge clk);
    chk1("pending b_valid", bus.b_valid, 1'b1);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk1("reset drops b_valid", bus.b_valid, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.b_ready = 1'b1;
    @(negedge clk);
    chk1("post-reset aw_ready", bus.aw_ready, 1'b1);
    chk("post-reset reg6", regs[223:192], 32'h0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end
endmodule

// File: doc/axi4_reg_slave.md
AXI4_REG_SLAVE -- requirements
Module: axi4_reg_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h2_0000, byte address of register 0.
REQ-002 SHALL have parameter NREGS, default 8, number of 32-bit registers (2..16); register i at BASE_ADDR+4*i.
REQ-003 SHALL have parameter IDLEN, default 5, AXI ID width.
REQ-004 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports aw_valid in 1 / aw_ready out 1: write address handshake.
REQ-007 SHALL have ports aw_addr  in  32  write byte address; aw_id  in  IDLEN  write ID.
REQ-008 SHALL have ports w_valid in 1 / w_ready out 1: write data handshake.
REQ-009 SHALL have ports w_data  in  32  write data; w_strb  in  4  byte enables.
REQ-010 SHALL have ports b_valid out 1 / b_ready in 1: write response handshake.
REQ-011 SHALL have ports b_resp  out  2  response code; b_id  out  IDLEN  echoed aw_id.
REQ-012 SHALL have ports ar_valid in 1 / ar_ready out 1: read address handshake.
REQ-013 SHALL have ports ar_addr  in  32  read byte address; ar_id  in  IDLEN  read ID.
REQ-014 SHALL have ports r_valid out 1 / r_ready in 1: read data handshake.
REQ-015 SHALL have ports r_data  out  32; r_resp  out  2; r_id  out  IDLEN  echoed ar_id.
REQ-016 SHALL have port regs  out  32*NREGS  flattened register contents, register i at bits [32*i+31:32*i].

Function
REQ-017 Write FSM SHALL have states W_IDLE, W_HAVE_A (AW taken, waiting W), W_HAVE_D (W taken, waiting AW), W_RESP.
REQ-018 aw_ready SHALL be 1 in W_IDLE and W_HAVE_D only; w_ready SHALL be 1 in W_IDLE and W_HAVE_A only; neither depends combinationally on valid.
REQ-019 W_IDLE: AW and W same cycle -> W_RESP; AW only -> W_HAVE_A; W only -> W_HAVE_D; W_HAVE_A/W_HAVE_D -> W_RESP on missing handshake.
REQ-020 Register update SHALL occur at the edge entering W_RESP, byte lanes per w_strb; b_valid=1 from next cycle, held with stable b_resp/b_id until b_ready, then W_IDLE.
REQ-021 Decode: index=(addr-BASE_ADDR)>>2, addr[1:0] ignored; addr below BASE_ADDR or index>=NREGS -> DECERR (2'b11), no state change, read data 32'h0.
REQ-022 Register 0 SHALL be read-only constant 32'hA5A5_0001; write to it -> SLVERR (2'b10), no update; all other valid accesses -> OKAY (2'b00).
REQ-023 w_strb=4'b0000 to writable register SHALL return OKAY with no update.
REQ-024 Read FSM SHALL have states R_IDLE (ar_ready=1) and R_RESP (ar_ready=0); r_data/r_resp/r_id captured at AR handshake, r_valid=1 next cycle, held stable until r_ready, then R_IDLE.
REQ-025 Read and write paths SHALL be independent; read captured on same edge as a write commit to the same register SHALL return the pre-write value.
REQ-026 Throughput: one write per 2 cycles minimum (b_ready held 1), one read per 2 cycles minimum.

Reset
REQ-027 On rst_n=0: write FSM W_IDLE, read FSM R_IDLE, aw_ready=w_ready=ar_ready=1 after release, b_valid=r_valid=0, b_resp=r_resp=0, b_id=r_id=0, r_data=0, registers 1..NREGS-1 = 0; reset mid-transaction SHALL drop the pending response.

Verification
REQ-028 AW+W same cycle addr 32'h2_0004 data 32'h1234_5678 strb 4'hF -> b_valid next cycle, OKAY, b_id=aw_id; regs[63:32]=32'h1234_5678.
REQ-029 W first (data 32'hFFFF_FFFF, strb 4'b0101) to 32'h2_0008, AW three cycles later -> W_HAVE_D then W_RESP; register 2 = 32'h00FF_00FF from zero.
REQ-030 Read 32'h2_0000 -> r_data 32'hA5A5_0001 OKAY; write 32'h2_0000 -> SLVERR, value unchanged.
REQ-031 Read 32'h2_0020 and 32'h1_FFFC with NREGS=8 -> DECERR, r_data 0; write same -> DECERR, regs unchanged.
REQ-032 b_ready/r_ready held 0 for 5 cycles -> b_valid/r_valid and payloads stable, aw_ready/w_ready/ar_ready 0 throughout.
REQ-033 Read and write of register 3 accepted same cycle (old 32'h0, new 32'hCAFE_F00D) -> r_data 32'h0; subsequent read 32'hCAFE_F00D.
